clock_divider_bank: RTL and testbench
=====================================

Name: clock_divider_bank

Overview:
- Bank of NUM_CH independent, runtime-programmable clock-enable generators driven from the single system clock.
- Each channel produces:
  - a one-cycle tick pulse, used as a clock enable by downstream logic;
  - a near-50% duty square wave, clk_out, for display/LED/game-timer use.
- Replaces fixed divide-by-4 / divide-to-1Hz logic with per-channel divisors loadable at run time.
- Provides global phase sync and per-channel enables.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 32, width of divisor and counter per channel.
- DEFAULT_DIV, 100_000_000, divisor loaded into every channel at reset (1 Hz from 100 MHz).
- CH_W, derived localparam = max(1, clog2(NUM_CH)), width of channel-select bus.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_i  in  1  global phase restart; all counters to 0.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CH_W  target channel for write.
- wr_div  in  CNT_W  new divisor value.
- wr_err  out  1  one-cycle pulse: write to wr_ch >= NUM_CH.
- tick  out  NUM_CH  per-channel one-cycle pulse, once per divisor period.
- clk_out  out  NUM_CH  per-channel square wave.

Behaviour:
- Reset (rst_n low, async):
  - div[i] = DEFAULT_DIV, cnt[i] = 0.
  - tick = 0, clk_out = 0, wr_err = 0, pending state cleared.
  - All outputs registered; none combinational from inputs.
- Per channel i, each clk edge, in priority order:
  1. ch_en[i]=0 or div[i]=0: cnt<=0, tick<=0, clk_out<=0 (channel idle).
  2. sync_i=1: cnt<=0, tick<=0, clk_out<=1 if div>=2 else 0.
  3. Otherwise:
     - tick <= (cnt==div-1).
     - clk_out <= (div>=2) && (cnt < div - div/2).
     - cnt <= (cnt==div-1) ? 0 : cnt+1.
- Timing consequences:
  - First tick is asserted D cycles after the first edge sampling ch_en high with cnt=0; thereafter exactly every D cycles.
  - clk_out is high for ceil(D/2) cycles and low for floor(D/2) cycles, aligned so the high phase starts the cycle after cnt=0.
- Divisor edge cases:
  - D=1: tick high every enabled cycle; clk_out held 0.
  - D=0: channel treated as disabled.
- Arithmetic:
  - div-1 and div/2 computed in CNT_W bits; D=0 never reaches the subtraction path.
  - Counter never exceeds div-1.
- Divisor write:
  - wr_en=1 with wr_ch<NUM_CH updates channel wr_ch (see Optional Feature).
  - wr_ch>=NUM_CH: no state change; wr_err<=1 for one cycle.
  - wr_err is otherwise 0.
- Simultaneous events:
  - Write and wrap on the same channel in the same cycle: write wins (see Optional Feature for timing).
  - sync_i with a write: both apply; counter still restarts at 0.
- Channels are fully independent except through sync_i and the shared write bus.

Optional Feature:
- Macro: CLKDIV_SHADOW_EN.
- Defined (shadow mode):
  - A write stores wr_div in shadow[i] and sets pending[i]; the running period is not disturbed.
  - Shadow is copied into div[i] (pending cleared) on the cycle the counter wraps (cnt==div-1), on sync_i, or immediately if the channel is idle.
  - A second write before the apply overwrites the shadow; the last write wins.
- Undefined (immediate mode):
  - A write updates div[i] immediately and forces cnt[i]<=0 and tick[i]<=0 that cycle; the new period starts from 0.

Test Plan:
- Reset, DEFAULT_DIV overridden to 4, ch_en=1 on ch0 -> tick[0] high on cycles 4, 8, 12 after enable; clk_out[0] pattern 1,1,0,0 repeating; other channels all 0.
- Odd divisor D=5 written to ch1 and enabled -> clk_out[1] high 3 cycles, low 2; tick[1] every 5 cycles; no glitches.
- D=1 on ch2 -> tick[2] constantly 1 while enabled, clk_out[2]=0. Then D=0 -> tick[2]=0, clk_out[2]=0.
- Ch0 D=4, ch1 D=6 free-running, assert sync_i mid-period -> both counters restart; next ticks at exactly 4 and 6 cycles after sync.
- Write D=8 to ch0 at cnt=1 of a D=4 period:
  - Shadow build: current tick still at cnt=3, then 8-cycle period follows.
  - Immediate build: counter restarts, next tick 8 cycles after the write.
- Write with wr_ch=NUM_CH -> wr_err pulses one cycle, all divisors unchanged. Then deassert rst_n mid-count -> all outputs 0 immediately, divisors return to DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Bank of runtime-programmable clock-enable generators: per channel a one-cycle tick and a near-50% square wave.
// Define CLKDIV_SHADOW_EN to buffer divisor writes until the next period boundary instead of restarting the channel.
module clock_divider_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100_000_000,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_sync,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [CNT_W-1:0]  i_wr_div,
    output logic              o_wr_err,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_clk_out
);

    logic r_wr_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= i_wr_en && (32'(i_wr_ch) >= NUM_CH);
        end
    end

    assign o_wr_err = r_wr_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div;
        logic             r_tick;
        logic             r_clk_out;
        logic             w_hit;
        logic             w_idle;
        logic             w_last;
        logic             w_hi;
        logic             w_restart;
        logic [CNT_W-1:0] w_div_next;

        assign w_hit  = i_wr_en && (i_wr_ch == CH_W'(gi));
        // A zero divisor parks the channel, so the div-1 compare only matters while running.
        assign w_idle = !i_ch_en[gi] || (r_div == '0);
        assign w_last = !w_idle && (r_cnt == r_div - CNT_W'(1));
        assign w_hi   = (r_div >= CNT_W'(2)) && (r_cnt < r_div - (r_div >> 1));

`ifdef CLKDIV_SHADOW_EN
        logic [CNT_W-1:0] r_shadow;
        logic             r_pending;
        logic [CNT_W-1:0] w_shadow_eff;
        logic             w_pend_eff;
        logic             w_apply;

        // A write landing on the apply cycle takes effect directly, so the last write always wins.
        assign w_shadow_eff = w_hit ? i_wr_div : r_shadow;
        assign w_pend_eff   = w_hit || r_pending;
        assign w_apply      = w_pend_eff && (w_idle || i_sync || w_last);
        assign w_div_next   = w_apply ? w_shadow_eff : r_div;
        assign w_restart    = 1'b0;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_shadow  <= CNT_W'(DEFAULT_DIV);
                r_pending <= 1'b0;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end else if (w_hit) begin
                r_shadow  <= i_wr_div;
                r_pending <= 1'b1;
            end
        end
`else
        assign w_div_next = w_hit ? i_wr_div : r_div;
        assign w_restart  = w_hit;
`endif

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt     <= '0;
                r_div     <= CNT_W'(DEFAULT_DIV);
                r_tick    <= 1'b0;
                r_clk_out <= 1'b0;
            end else begin
                r_div <= w_div_next;
                if (w_idle) begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b0;
                    r_clk_out <= 1'b0;
                end else if (i_sync || w_restart) begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b0;
                    r_clk_out <= (w_div_next >= CNT_W'(2));
                end else begin
                    r_tick    <= w_last;
                    r_clk_out <= w_hi;
                    r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
                end
            end
        end

        assign o_tick[gi]    = r_tick;
        assign o_clk_out[gi] = r_clk_out;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed table-driven bench for clock_divider_bank (3 channels, reset divisor 4); follows CLKDIV_SHADOW_EN if defined.
module tb_clock_divider_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync_s = 1'b0;
    logic              wr_en = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [CNT_W-1:0]  wr_div = '0;
    logic              wr_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    clock_divider_bank #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_ch_en  (ch_en),
        .i_sync   (sync_s),
        .i_wr_en  (wr_en),
        .i_wr_ch  (wr_ch),
        .i_wr_div (wr_div),
        .o_wr_err (wr_err),
        .o_tick   (tick),
        .o_clk_out(clk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  en;
        logic        sync;
        logic        we;
        logic [1:0]  ch;
        logic [31:0] dv;
        logic [2:0]  tick;
        logic [2:0]  clk;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(string tag, logic [2:0] en, logic s, logic we, logic [1:0] ch,
                                logic [31:0] dv, logic [2:0] t, logic [2:0] c, logic e);
        vec_t v;
        v.tag = tag; v.en = en; v.sync = s; v.we = we; v.ch = ch; v.dv = dv;
        v.tick = t; v.clk = c; v.err = e;
        vecs.push_back(v);
    endfunction

    function automatic void run(string tag, logic [2:0] en, logic [2:0] t, logic [2:0] c);
        add(tag, en, 1'b0, 1'b0, 2'd0, 32'd0, t, c, 1'b0);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_table();
        // ch0 on reset divisor 4: clk_out 1,1,0,0 and tick every 4th cycle
        for (int k = 1; k <= 12; k++)
            run("d4_ch0", 3'b001, {2'b00, (k % 4) == 0}, {2'b00, ((k - 1) % 4) < 2});
        run("d4_off", 3'b000, 3'b000, 3'b000);

        // ch1 divisor 5: high 3, low 2
        add("wr_d5", 3'b000, 1'b0, 1'b1, 2'd1, 32'd5, 3'b000, 3'b000, 1'b0);
        for (int k = 1; k <= 10; k++)
            run("d5_ch1", 3'b010, {1'b0, (k % 5) == 0, 1'b0}, {1'b0, ((k - 1) % 5) < 3, 1'b0});
        run("d5_off", 3'b000, 3'b000, 3'b000);

        // ch2 divisor 1, then 0
        add("wr_d1", 3'b000, 1'b0, 1'b1, 2'd2, 32'd1, 3'b000, 3'b000, 1'b0);
        for (int k = 1; k <= 4; k++)
            run("d1_ch2", 3'b100, 3'b100, 3'b000);
`ifdef CLKDIV_SHADOW_EN
        add("wr_d0", 3'b100, 1'b0, 1'b1, 2'd2, 32'd0, 3'b100, 3'b000, 1'b0);
`else
        add("wr_d0", 3'b100, 1'b0, 1'b1, 2'd2, 32'd0, 3'b000, 3'b000, 1'b0);
`endif
        for (int k = 1; k <= 3; k++)
            run("d0_ch2", 3'b100, 3'b000, 3'b000);
        run("d0_off", 3'b000, 3'b000, 3'b000);

        // ch0 D=4 and ch1 D=6 free-running, sync mid-period
        add("wr_d6", 3'b000, 1'b0, 1'b1, 2'd1, 32'd6, 3'b000, 3'b000, 1'b0);
        run("sync_pre", 3'b011, 3'b000, 3'b011);
        run("sync_pre", 3'b011, 3'b000, 3'b011);
        run("sync_pre", 3'b011, 3'b000, 3'b010);
        run("sync_pre", 3'b011, 3'b001, 3'b000);
        run("sync_pre", 3'b011, 3'b000, 3'b001);
        run("sync_pre", 3'b011, 3'b010, 3'b001);
        run("sync_pre", 3'b011, 3'b000, 3'b010);
        add("sync", 3'b011, 1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b011, 1'b0);
        run("sync_post", 3'b011, 3'b000, 3'b011);
        run("sync_post", 3'b011, 3'b000, 3'b011);
        run("sync_post", 3'b011, 3'b000, 3'b010);
        run("sync_post", 3'b011, 3'b001, 3'b000);
        run("sync_post", 3'b011, 3'b000, 3'b001);
        run("sync_post", 3'b011, 3'b010, 3'b001);
        run("sync_off", 3'b000, 3'b000, 3'b000);

        // divisor 8 written to ch0 at cnt=1 of a divisor-4 period
        run("wr8_pre", 3'b001, 3'b000, 3'b001);
        add("wr8", 3'b001, 1'b0, 1'b1, 2'd0, 32'd8, 3'b000, 3'b001, 1'b0);
`ifdef CLKDIV_SHADOW_EN
        run("wr8_post", 3'b001, 3'b000, 3'b000);
        run("wr8_post", 3'b001, 3'b001, 3'b000);
        for (int k = 1; k <= 8; k++)
            run("wr8_post", 3'b001, {2'b00, k == 8}, {2'b00, k <= 4});
`else
        for (int k = 1; k <= 8; k++)
            run("wr8_post", 3'b001, {2'b00, k == 8}, {2'b00, k <= 4});
        run("wr8_post", 3'b001, 3'b000, 3'b001);
        run("wr8_post", 3'b001, 3'b000, 3'b001);
`endif
        run("wr8_off", 3'b000, 3'b000, 3'b000);

        // out-of-range write: error pulse, divisors untouched (ch0=8, ch1=6, ch2=0)
        add("wr_bad", 3'b000, 1'b0, 1'b1, 2'd3, 32'd2, 3'b000, 3'b000, 1'b1);
        run("wr_bad_after", 3'b000, 3'b000, 3'b000);
        run("keep", 3'b111, 3'b000, 3'b011);
        run("keep", 3'b111, 3'b000, 3'b011);
        run("keep", 3'b111, 3'b000, 3'b011);
        run("keep", 3'b111, 3'b000, 3'b001);
        run("keep", 3'b111, 3'b000, 3'b000);
        run("keep", 3'b111, 3'b010, 3'b000);
        run("keep", 3'b111, 3'b000, 3'b010);
        run("keep", 3'b111, 3'b001, 3'b010);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_wr_err", 32'(wr_err), 32'd0);
        rst_n = 1'b1;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            ch_en  = vecs[i].en;
            sync_s = vecs[i].sync;
            wr_en  = vecs[i].we;
            wr_ch  = vecs[i].ch;
            wr_div = vecs[i].dv;
            step();
            $display("vec %0d %s en=%b sync=%b we=%b ch=%0d div=%0d -> tick=%b clk_out=%b wr_err=%b",
                     i, vecs[i].tag, vecs[i].en, vecs[i].sync, vecs[i].we, vecs[i].ch, vecs[i].dv,
                     tick, clk_out, wr_err);
            check($sformatf("%s[%0d].tick", vecs[i].tag, i), 32'(tick), 32'(vecs[i].tick));
            check($sformatf("%s[%0d].clk_out", vecs[i].tag, i), 32'(clk_out), 32'(vecs[i].clk));
            check($sformatf("%s[%0d].wr_err", vecs[i].tag, i), 32'(wr_err), 32'(vecs[i].err));
        end
        wr_en  = 1'b0;
        sync_s = 1'b0;

        // asynchronous reset mid-count: outputs clear before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-count -> tick=%b clk_out=%b wr_err=%b", tick, clk_out, wr_err);
        check("async_rst_tick", 32'(tick), 32'd0);
        check("async_rst_clk_out", 32'(clk_out), 32'd0);
        check("async_rst_wr_err", 32'(wr_err), 32'd0);
        ch_en = 3'b011;
        step();
        check("held_rst_clk_out", 32'(clk_out), 32'd0);
        rst_n = 1'b1;

        // divisors back to the reset value of 4 on ch0 and ch1
        for (int k = 1; k <= 4; k++) begin
            step();
            $display("post-reset cycle %0d -> tick=%b clk_out=%b", k, tick, clk_out);
            check($sformatf("post_rst[%0d].tick", k), 32'(tick), (k == 4) ? 32'd3 : 32'd0);
            check($sformatf("post_rst[%0d].clk_out", k), 32'(clk_out), (k <= 2) ? 32'd3 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
